// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the instruction prefetch path.
package pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } prefetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & INST_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Circular buffer of fetched words with their PCs; head entry is read straight
// from the slot registers so the consumer sees it without an extra cycle.
module prefetch_fifo
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             srst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [XLEN-1:0]  push_inst_i,
    input  logic [XLEN-1:0]  push_pc_i,
    input  logic             pop_i,
    output logic [XLEN-1:0]  head_inst_o,
    output logic [XLEN-1:0]  head_pc_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     wr_entry;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [DEPTH-1:0] wr_en;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push_i && !flush_i;
    assign do_pop   = pop_i && !flush_i && !empty_o;
    assign wr_entry = '{inst: push_inst_i, pc: push_pc_i};

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_dec
        assign wr_en[gi] = do_push && (tail_q == PTR_W'(gi));
    end

    // Slots are cleared on reset so the head reads as zero before any fetch.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (srst_i) begin
                mem_q[i] <= '0;
            end else if (wr_en[i]) begin
                mem_q[i] <= wr_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst_i || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                tail_q <= tail_q + 1'b1;
            end
            if (do_pop) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_inst_o = mem_q[head_q].inst;
    assign head_pc_o   = mem_q[head_q].pc;
    assign count_o     = count_q;
    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetcher: request FSM, fetch PC and issue control
// in front of prefetch_fifo. Optional combinational bypass: PREFETCH_BYPASS_EN.
module inst_prefetch_buffer
    import pipe_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic [31:0] inst_mem_address,
    output logic        inst_mem_is_ready,
    input  logic [31:0] inst_mem_read_data,
    input  logic        inst_mem_is_valid,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 2;

    prefetch_state_t state_q;
    logic [XLEN-1:0] fetch_pc_q;

    logic             outstanding;
    logic             capture;
    logic             bypass_hit;
    logic             pop;
    logic             issue;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0] occupancy;
    logic [XLEN-1:0]  fifo_inst;
    logic [XLEN-1:0]  fifo_pc;

    assign outstanding = (state_q != IDLE);
    assign capture     = (state_q == WAIT) && inst_mem_is_valid && !flush && !reset;

`ifdef PREFETCH_BYPASS_EN
    assign bypass_hit = capture && fifo_empty;
`else
    assign bypass_hit = 1'b0;
`endif

    assign inst_valid = !fifo_empty || bypass_hit;
    assign inst       = bypass_hit ? inst_mem_read_data : fifo_inst;
    assign inst_pc    = bypass_hit ? fetch_pc_q : fifo_pc;

    assign pop       = inst_valid && inst_ready && !flush && !reset;
    assign fifo_pop  = pop && !fifo_empty;
    assign fifo_push = capture && !(bypass_hit && inst_ready) && (!fifo_full || fifo_pop);

    // Counting the in-flight request keeps a slot reserved for its response.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(outstanding) + OCC_W'(capture) - OCC_W'(pop);
    assign issue     = !reset && !flush && (occupancy < OCC_W'(DEPTH));

    assign inst_mem_is_ready = issue;
    assign inst_mem_address  = capture ? fetch_pc_q + 32'd4 : fetch_pc_q;

    // DROP swallows the response slot of the flushed request, but the first
    // fetch of the redirect target may already go out in that same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
        end else if (flush) begin
            fetch_pc_q <= align_pc(flush_pc);
            state_q    <= (state_q == WAIT) ? DROP : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= issue ? WAIT : IDLE;
                end
                WAIT: begin
                    if (capture) begin
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                    end
                    state_q <= issue ? WAIT : IDLE;
                end
                DROP: begin
                    state_q <= issue ? WAIT : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    prefetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .srst_i     (reset),
        .flush_i    (flush),
        .push_i     (fifo_push),
        .push_inst_i(inst_mem_read_data),
        .push_pc_i  (fetch_pc_q),
        .pop_i      (fifo_pop),
        .head_inst_o(fifo_inst),
        .head_pc_o  (fifo_pc),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

endmodule
